// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between a core (A)
// and a loader (B); at most one access is in flight at any time.
module data_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_enable,
  output logic              mem_read_writenot,
  output logic [ADDR_W-1:0] mem_address1,
  output logic [ADDR_W-1:0] mem_address2,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_b_q, owner_b_d;
  logic                prio_b_q, prio_b_d;
  logic                a_gnt_q, a_gnt_d;
  logic                b_gnt_q, b_gnt_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_rwn_q, mem_rwn_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                req_any;
  logic                win_b;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // B wins when it is alone or when the round-robin pointer favours it.
  assign req_any   = a_req | b_req;
  assign win_b     = b_req & (~a_req | prio_b_q);
  assign sel_we    = win_b ? b_we    : a_we;
  assign sel_addr  = win_b ? b_addr  : a_addr;
  assign sel_wdata = win_b ? b_wdata : a_wdata;

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_b_q    <= 1'b0;
      prio_b_q     <= 1'b0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= {DATA_W{1'b0}};
      b_rdata_q    <= {DATA_W{1'b0}};
      mem_enable_q <= 1'b0;
      mem_rwn_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_b_q    <= owner_b_d;
      prio_b_q     <= prio_b_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      mem_enable_q <= mem_enable_d;
      mem_rwn_q    <= mem_rwn_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next state, access owner and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    owner_b_d = owner_b_q;
    prio_b_d  = prio_b_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d   = ACCESS;
          owner_b_d = win_b;
          prio_b_d  = ~win_b;
        end else begin
          state_d   = IDLE;
        end
      end
      ACCESS: begin
        // mem_rwn_q still holds the latched direction of this access
        if (mem_rwn_q) begin
          state_d = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output values for the next cycle.
  always_comb begin
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    mem_enable_d = 1'b0;
    mem_rwn_d    = mem_rwn_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          a_gnt_d      = ~win_b;
          b_gnt_d      = win_b;
          mem_enable_d = 1'b1;
          mem_rwn_d    = ~sel_we;
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
        end else begin
          mem_enable_d = 1'b0;
        end
      end
      RESP: begin
        if (owner_b_q) begin
          b_rvalid_d = 1'b1;
          b_rdata_d  = mem_out_data1;
        end else begin
          a_rvalid_d = 1'b1;
          a_rdata_d  = mem_out_data1;
        end
      end
      default: begin
        mem_enable_d = 1'b0;
      end
    endcase
  end

  assign a_gnt             = a_gnt_q;
  assign b_gnt             = b_gnt_q;
  assign a_rvalid          = a_rvalid_q;
  assign b_rvalid          = b_rvalid_q;
  assign a_rdata           = a_rdata_q;
  assign b_rdata           = b_rdata_q;
  assign mem_enable        = mem_enable_q;
  assign mem_read_writenot = mem_rwn_q;
  assign mem_address1      = mem_addr_q;
  assign mem_write_address = mem_addr_q;
  assign mem_address2      = {ADDR_W{1'b0}};
  assign mem_in_data       = mem_wdata_q;

endmodule
